pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit_pkg.sv | 20 ++
 rtl/pc_fetch_unit_addr_check.sv | 16 +
 rtl/pc_fetch_unit.sv | 109 ++++++++++
 tb/tb_pc_fetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: address-map and exception-code constants shared by the
// fetch unit, CP0 and the instruction memory, plus the IF/ID record type.
package pc_fetch_unit_pkg;

  localparam logic [31:0] PC_RESET     = 32'h0000_3000;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
  localparam logic [31:0] TEXT_BASE    = 32'h0000_3000;
  localparam logic [31:0] TEXT_END     = 32'h0000_6FFC;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [4:0]  exccode;
  } if_id_t;

endpackage

// File: rtl/pc_fetch_unit_addr_check.sv
// fetch_addr_check: combinational fetch-address legality check.
//   pc    : address being fetched
//   fault : 1 when pc is misaligned or outside [LO, HI]
module fetch_addr_check
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] LO = TEXT_BASE,
  parameter logic [31:0] HI = TEXT_END
) (
  input  logic [31:0] pc,
  output logic        fault
);

  assign fault = (pc[1:0] != 2'b00) || (pc < LO) || (pc > HI);

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the PC, drives the IM fetch address and captures the
// returned word into IF/ID. Handles sequential advance, redirect with delay
// slot, stall, exception entry, eret and fetch address faults (AdEL).
// Ports:
//   clk, reset (sync, active-high), stall, redirect_valid/redirect_target,
//   exc_req, eret_req/epc, instr_in (IM word for pc_out)
//   pc_out, if_id_instr, if_id_pc, if_id_valid, if_id_exccode
// Optional: define FETCH_PERF_CNT_EN to add output fetch_count, the number of
//   clean (valid, fault-free) IF/ID loads.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic [4:0]  if_id_exccode
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  logic [31:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  logic        fetch_fault;
  logic        load_if_id;

  fetch_addr_check #(
    .LO(TEXT_BASE),
    .HI(TEXT_END)
  ) u_addr_check (
    .pc   (pc_q),
    .fault(fetch_fault)
  );

  // exc_req and eret_req both override stall; stall freezes everything,
  // including a pending redirect.
  always_comb begin
    pc_d       = pc_q;
    if_id_d    = if_id_q;
    load_if_id = 1'b0;
    if (exc_req) begin
      pc_d    = HANDLER_ADDR;
      if_id_d = '0;
    end else if (eret_req) begin
      pc_d    = epc;
      if_id_d = '0;
    end else if (!stall) begin
      load_if_id       = 1'b1;
      pc_d             = redirect_valid ? redirect_target : pc_q + 32'd4;
      if_id_d.pc       = pc_q;
      if_id_d.valid    = 1'b1;
      // A faulting fetch enters the pipe as a nop tagged AdEL; CP0 takes it later.
      if_id_d.instr    = fetch_fault ? '0 : instr_in;
      if_id_d.exccode  = fetch_fault ? EXC_ADEL : EXC_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      if_id_q <= '0;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  assign pc_out        = pc_q;
  assign if_id_instr   = if_id_q.instr;
  assign if_id_pc      = if_id_q.pc;
  assign if_id_valid   = if_id_q.valid;
  assign if_id_exccode = if_id_q.exccode;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (load_if_id && !fetch_fault) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  logic unused_load;
  assign unused_load = load_if_id;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC  = 32'h0000_3000;
  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] LO      = 32'h0000_3000;
  localparam logic [31:0] HI      = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, exc_req, eret_req;
  logic [31:0] redirect_target, epc, instr_in, pc_out, if_id_instr, if_id_pc;
  logic        if_id_valid;
  logic [4:0]  if_id_exccode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory model: a word that is distinct from its address.
  function automatic logic [31:0] im(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign instr_in = im(pc_out);

  pc_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .exc_req        (exc_req),
    .eret_req       (eret_req),
    .epc            (epc),
    .instr_in       (instr_in),
    .pc_out         (pc_out),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_valid    (if_id_valid),
    .if_id_exccode  (if_id_exccode)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a < LO) || (a > HI);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Expected instruction follows from the IF/ID contents: only a clean load carries a word.
  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ipc,
                         input logic e_v, input logic [4:0] e_ec, input logic [31:0] e_cnt);
    logic [31:0] e_instr;
    e_instr = (e_v && e_ec == 5'd0) ? im(e_ipc) : 32'd0;
    chk({tag, ".pc_out"}, pc_out, e_pc);
    chk({tag, ".if_id_pc"}, if_id_pc, e_ipc);
    chk({tag, ".if_id_instr"}, if_id_instr, e_instr);
    chk({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, e_v});
    chk({tag, ".if_id_exccode"}, {27'd0, if_id_exccode}, {27'd0, e_ec});
`ifdef FETCH_PERF_CNT_EN
    chk({tag, ".fetch_count"}, fetch_count, e_cnt);
`else
    if (e_cnt == 32'hFFFF_FFFF) $display("note: count wrap");
`endif
  endtask

  task automatic apply(input logic rst, input logic st, input logic rv, input logic [31:0] tgt,
                       input logic ex, input logic er, input logic [31:0] ep);
    reset = rst; stall = st; redirect_valid = rv; redirect_target = tgt;
    exc_req = ex; eret_req = er; epc = ep;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        st, rv, ex, er;
    logic [31:0] tgt, ep;
    logic [31:0] e_pc, e_ipc;
    logic        e_v;
    logic [4:0]  e_ec;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] tgt,
                              input logic ex, input logic er, input logic [31:0] ep,
                              input logic [31:0] e_pc, input logic [31:0] e_ipc,
                              input logic e_v, input logic [4:0] e_ec);
    vec_t v;
    v.st = st; v.rv = rv; v.tgt = tgt; v.ex = ex; v.er = er; v.ep = ep;
    v.e_pc = e_pc; v.e_ipc = e_ipc; v.e_v = e_v; v.e_ec = e_ec;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [31:0] prev_pc, cnt;
    logic [31:0] m_pc, m_ipc, m_cnt;
    logic        m_v;
    logic [4:0]  m_ec;

    //               st rv tgt            ex er epc            pc             ifpc          v  ec
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 32'h0000_3000, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3008, 32'h0000_3004, 1, 0));
    vecs.push_back(mk(1, 1, 32'h3100,     0, 0, 32'h0,        32'h0000_3008, 32'h0000_3004, 1, 0));
    vecs.push_back(mk(1, 1, 32'h3100,     0, 0, 32'h0,        32'h0000_3008, 32'h0000_3004, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_300C, 32'h0000_3008, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3010, 32'h0000_300C, 1, 0));
    vecs.push_back(mk(0, 1, 32'h3100,     0, 0, 32'h0,        32'h0000_3100, 32'h0000_3010, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3104, 32'h0000_3100, 1, 0));
    vecs.push_back(mk(0, 1, 32'h3020,     0, 0, 32'h0,        32'h0000_3020, 32'h0000_3104, 1, 0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        32'h0000_4180, 32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h3024,     32'h0000_3024, 32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3028, 32'h0000_3024, 1, 0));
    vecs.push_back(mk(0, 1, 32'h3002,     0, 0, 32'h0,        32'h0000_3002, 32'h0000_3028, 1, 0));
    vecs.push_back(mk(0, 1, 32'h7000,     0, 0, 32'h0,        32'h0000_7000, 32'h0000_3002, 1, 4));
    vecs.push_back(mk(0, 1, 32'h6FFC,     0, 0, 32'h0,        32'h0000_6FFC, 32'h0000_7000, 1, 4));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_7000, 32'h0000_6FFC, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 1, 32'h3024,     32'h0000_4180, 32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h2FFC,     32'h0000_2FFC, 32'h0,         0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 32'h0000_2FFC, 1, 4));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,       32'hFFFF_FFFC, 32'h0000_3000, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0000, 32'hFFFF_FFFC, 1, 4));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0004, 32'h0000_0000, 1, 4));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 32'h3000,     32'h0000_3000, 32'h0,         0, 0));

    // Reset state
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0);
    chk_all("reset", RST_PC, 32'h0, 0, 0, 32'h0);

    // Directed table; the count advances on every unstalled, unflushed, non-faulting fetch.
    prev_pc = RST_PC;
    cnt = 0;
    foreach (vecs[i]) begin
      if (!vecs[i].ex && !vecs[i].er && !vecs[i].st && !bad_addr(prev_pc)) cnt++;
      apply(0, vecs[i].st, vecs[i].rv, vecs[i].tgt, vecs[i].ex, vecs[i].er, vecs[i].ep);
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ipc, vecs[i].e_v, vecs[i].e_ec, cnt);
      prev_pc = vecs[i].e_pc;
    end

    // Reset asserted mid-stall with a redirect pending
    apply(0, 0, 0, 0, 0, 0, 0);
    apply(1, 1, 1, 32'h3100, 0, 0, 0);
    chk_all("reset_mid_stall", RST_PC, 32'h0, 0, 0, 32'h0);
    // Reset asserted alongside an exception
    apply(0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 1, 32'h5000, 1, 1, 32'h3300);
    chk_all("reset_vs_exc", RST_PC, 32'h0, 0, 0, 32'h0);

    // Randomized run against a behavioural model
    m_pc = RST_PC; m_ipc = 0; m_v = 0; m_ec = 0; m_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      logic        r_rst, r_st, r_rv, r_ex, r_er;
      logic [31:0] r_tgt, r_ep;
      r_rst = ($urandom % 80) == 0;
      r_ex  = ($urandom % 20) == 0;
      r_er  = ($urandom % 15) == 0;
      r_st  = ($urandom % 5) == 0;
      r_rv  = ($urandom % 4) == 0;
      case ($urandom % 8)
        0:       r_tgt = $urandom;
        1:       r_tgt = HI - 4 * ($urandom % 3);
        default: r_tgt = LO + 4 * ($urandom % 4096);
      endcase
      r_ep = (($urandom % 6) == 0) ? $urandom : LO + 4 * ($urandom % 4096);

      if (r_rst) begin
        m_pc = RST_PC; m_ipc = 0; m_v = 0; m_ec = 0; m_cnt = 0;
      end else if (r_ex) begin
        m_pc = HANDLER; m_ipc = 0; m_v = 0; m_ec = 0;
      end else if (r_er) begin
        m_pc = r_ep; m_ipc = 0; m_v = 0; m_ec = 0;
      end else if (!r_st) begin
        m_ipc = m_pc;
        m_v   = 1;
        m_ec  = bad_addr(m_pc) ? 5'd4 : 5'd0;
        if (!bad_addr(m_pc)) m_cnt = m_cnt + 1;
        m_pc  = r_rv ? r_tgt : m_pc + 32'd4;
      end

      apply(r_rst, r_st, r_rv, r_tgt, r_ex, r_er, r_ep);
      chk_all($sformatf("rnd%0d", n), m_pc, m_ipc, m_v, m_ec, m_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
